// File: rtl/uart_alu_ctrl.sv
// Packet sequencer between uart_rx and uart_tx: echoes payloads or reduces 32-bit operands (add/mul).
// Optional multiplier enabled by defining UART_ALU_MUL_EN; otherwise MulOpcode is an unknown command.
module uart_alu_ctrl #(
    parameter logic [7:0] EchoOpcode = 8'hEC,
    parameter logic [7:0] AddOpcode  = 8'hA0,
    parameter logic [7:0] MulOpcode  = 8'hA1
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [7:0] rx_data_i,
    input  logic       rx_valid_i,
    output logic       rx_ready_o,
    output logic [7:0] tx_data_o,
    output logic       tx_valid_o,
    input  logic       tx_ready_i,
    output logic       busy_o,
    output logic       err_o
);

`ifdef UART_ALU_MUL_EN
    localparam bit MulEnabled = 1'b1;
`else
    localparam bit MulEnabled = 1'b0;
`endif

    typedef enum logic [3:0] {
        HDR0, HDR1, HDR2, HDR3, ECHO_RX, ECHO_TX, ACC, SEND, DRAIN
    } state_t;

    state_t      state;
    logic [7:0]  opcode;
    logic [7:0]  len_lo;
    logic [15:0] cnt;
    logic [31:0] acc;
    logic [23:0] op_sr;
    logic [1:0]  byte_idx;
    logic [1:0]  send_idx;
`ifdef UART_ALU_MUL_EN
    logic        first_op;
`endif

    logic        rx_hs, tx_hs;
    logic [15:0] len_full, pay_len;
    logic        is_echo, is_mul, is_acc_op, is_known;
    logic [31:0] operand, acc_next;

    assign rx_hs     = rx_valid_i && rx_ready_o;
    assign tx_hs     = tx_valid_o && tx_ready_i;
    assign len_full  = {rx_data_i, len_lo};
    assign pay_len   = (len_full < 16'd4) ? 16'd0 : len_full - 16'd4;
    assign is_echo   = (opcode == EchoOpcode);
    assign is_mul    = (opcode == MulOpcode);
    assign is_acc_op = (opcode == AddOpcode) || (MulEnabled && is_mul);
    assign is_known  = is_echo || is_acc_op;
    assign busy_o    = (state != HDR0);
    assign operand   = {rx_data_i, op_sr};

    // Accumulator update for the operand completing on this rx byte.
    always_comb begin
        acc_next = acc + operand;
`ifdef UART_ALU_MUL_EN
        if (is_mul) begin
            acc_next = first_op ? operand : acc * operand;
        end
`endif
    end

    always_comb begin
        rx_ready_o = 1'b0;
        case (state)
            HDR0, HDR1, HDR2, HDR3, ECHO_RX, ACC, DRAIN: rx_ready_o = 1'b1;
            default:                                    rx_ready_o = 1'b0;
        endcase
    end

    // Main sequencer; tx_data_o/tx_valid_o are loaded on the edge that enters ECHO_TX or SEND.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state      <= HDR0;
            opcode     <= 8'h00;
            len_lo     <= 8'h00;
            cnt        <= 16'h0000;
            acc        <= 32'h0;
            op_sr      <= 24'h0;
            byte_idx   <= 2'd0;
            send_idx   <= 2'd0;
            tx_data_o  <= 8'h00;
            tx_valid_o <= 1'b0;
            err_o      <= 1'b0;
`ifdef UART_ALU_MUL_EN
            first_op   <= 1'b1;
`endif
        end else begin
            case (state)
                HDR0: if (rx_hs) begin
                    opcode <= rx_data_i;
                    err_o  <= 1'b0;
                    state  <= HDR1;
                end
                HDR1: if (rx_hs) state <= HDR2;
                HDR2: if (rx_hs) begin
                    len_lo <= rx_data_i;
                    state  <= HDR3;
                end
                HDR3: if (rx_hs) begin
                    cnt      <= pay_len;
                    acc      <= 32'h0;
                    byte_idx <= 2'd0;
`ifdef UART_ALU_MUL_EN
                    first_op <= 1'b1;
`endif
                    if (len_full < 16'd4 || !is_known) err_o <= 1'b1;
                    if (is_acc_op) begin
                        if (pay_len == 16'd0) begin
                            state      <= SEND;
                            send_idx   <= 2'd0;
                            tx_data_o  <= 8'h00;
                            tx_valid_o <= 1'b1;
                        end else begin
                            state <= ACC;
                        end
                    end else if (pay_len == 16'd0) begin
                        state <= HDR0;
                    end else if (is_echo) begin
                        state <= ECHO_RX;
                    end else begin
                        state <= DRAIN;
                    end
                end
                ECHO_RX: if (rx_hs) begin
                    tx_data_o  <= rx_data_i;
                    tx_valid_o <= 1'b1;
                    cnt        <= cnt - 16'd1;
                    state      <= ECHO_TX;
                end
                ECHO_TX: if (tx_hs) begin
                    tx_valid_o <= 1'b0;
                    state      <= (cnt == 16'd0) ? HDR0 : ECHO_RX;
                end
                ACC: if (rx_hs) begin
                    cnt      <= cnt - 16'd1;
                    byte_idx <= byte_idx + 2'd1;
                    op_sr    <= {rx_data_i, op_sr[23:8]};
                    if (byte_idx == 2'd3) begin
                        acc <= acc_next;
`ifdef UART_ALU_MUL_EN
                        first_op <= 1'b0;
`endif
                    end
                    // Last payload byte: an incomplete trailing operand is dropped and flagged.
                    if (cnt == 16'd1) begin
                        state      <= SEND;
                        send_idx   <= 2'd0;
                        tx_valid_o <= 1'b1;
                        tx_data_o  <= (byte_idx == 2'd3) ? acc_next[7:0] : acc[7:0];
                        if (byte_idx != 2'd3) err_o <= 1'b1;
                    end
                end
                SEND: if (tx_hs) begin
                    if (send_idx == 2'd3) begin
                        tx_valid_o <= 1'b0;
                        state      <= HDR0;
                    end else begin
                        send_idx <= send_idx + 2'd1;
                        case (send_idx)
                            2'd0:    tx_data_o <= acc[15:8];
                            2'd1:    tx_data_o <= acc[23:16];
                            default: tx_data_o <= acc[31:24];
                        endcase
                    end
                end
                DRAIN: if (rx_hs) begin
                    cnt <= cnt - 16'd1;
                    if (cnt == 16'd1) state <= HDR0;
                end
                default: state <= HDR0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Scoreboard bench for uart_alu_ctrl: expected tx bytes are queued per packet and popped by a tx monitor.
module tb_uart_alu_ctrl;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic [7:0] rx_data_i;
    logic       rx_valid_i;
    logic       rx_ready_o;
    logic [7:0] tx_data_o;
    logic       tx_valid_o;
    logic       tx_ready_i;
    logic       busy_o;
    logic       err_o;

    logic [7:0] exp_q[$];
    logic [7:0] pkt[$];
    logic [7:0] mon_exp;
    int tests_run = 0;
    int tests_failed = 0;

    uart_alu_ctrl dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
        .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
        .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    // A tx handshake happens on the next rising edge whenever valid and ready are high here.
    always @(negedge clk_i) begin
        if (!reset_i && tx_valid_o && tx_ready_i) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("[TB] FAIL tx_unexpected: got %02h, required no tx byte", tx_data_o);
            end else begin
                mon_exp = exp_q.pop_front();
                if (tx_data_o !== mon_exp) begin
                    tests_failed++;
                    $display("[TB] FAIL tx_byte: got %02h, required %02h", tx_data_o, mon_exp);
                end
            end
        end
    end

    task automatic rx_byte(input logic [7:0] b);
        int n = 0;
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        @(negedge clk_i);
        while (!rx_ready_o && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        if (!rx_ready_o) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL rx_timeout: rx_ready_o got 0, required 1 within 200 cycles");
        end
        @(posedge clk_i);
        #1;
        rx_valid_i = 1'b0;
    endtask

    task automatic send_pkt();
        foreach (pkt[i]) rx_byte(pkt[i]);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk_i);
        while ((exp_q.size() != 0 || busy_o || tx_valid_o) && n < 500) begin
            @(negedge clk_i);
            n++;
        end
        tests_run++;
        if (exp_q.size() != 0 || busy_o) begin
            tests_failed++;
            $display("[TB] FAIL %s_idle: busy=%0b pending=%0d, required busy=0 pending=0",
                     name, busy_o, exp_q.size());
            exp_q.delete();
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_err(input string name, input logic expected);
        tests_run++;
        if (err_o !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s_err: got %0b, required %0b", name, err_o, expected);
        end
    endtask

    task automatic test_reset();
        reset_i = 1'b1; rx_valid_i = 1'b0; rx_data_i = 8'h00; tx_ready_i = 1'b1;
        #12;
        tests_run += 5;
        if (rx_ready_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_rx_ready: got %0b, required 1", rx_ready_o); end
        if (tx_valid_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_tx_valid: got %0b, required 0", tx_valid_o); end
        if (tx_data_o !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_tx_data: got %02h, required 00", tx_data_o); end
        if (busy_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %0b, required 0", busy_o); end
        if (err_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_err: got %0b, required 0", err_o); end
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
    endtask

    task automatic test_echo();
        pkt = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'h41, 8'h42};
        exp_q.push_back(8'h41); exp_q.push_back(8'h42);
        send_pkt();
        wait_idle("echo");
        check_err("echo", 1'b0);
    endtask

    task automatic test_add();
        pkt = '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
        exp_q.push_back(8'h03); exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        send_pkt();
        wait_idle("add");
        check_err("add", 1'b0);
    endtask

    task automatic test_add_wrap_stall();
        pkt = '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00};
        exp_q.push_back(8'h01); exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        tx_ready_i = 1'b0;
        send_pkt();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            tests_run += 3;
            if (tx_valid_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL stall_tx_valid: got %0b, required 1", tx_valid_o); end
            if (tx_data_o !== 8'h01) begin tests_failed++; $display("[TB] FAIL stall_tx_data: got %02h, required 01", tx_data_o); end
            if (rx_ready_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL stall_rx_ready: got %0b, required 0", rx_ready_o); end
        end
        @(posedge clk_i);
        #1;
        tx_ready_i = 1'b1;
        wait_idle("add_wrap");
        check_err("add_wrap", 1'b0);
    endtask

    task automatic test_edge_lengths();
        pkt = '{8'hA0, 8'h00, 8'h04, 8'h00};
        repeat (4) exp_q.push_back(8'h00);
        send_pkt();
        wait_idle("add_empty");
        check_err("add_empty", 1'b0);

        pkt = '{8'hEC, 8'h00, 8'h03, 8'h00};
        send_pkt();
        wait_idle("short_len");
        check_err("short_len", 1'b1);

        pkt = '{8'hA0, 8'h00, 8'h06, 8'h00, 8'h07, 8'h08};
        repeat (4) exp_q.push_back(8'h00);
        send_pkt();
        wait_idle("add_partial");
        check_err("add_partial", 1'b1);
    endtask

    task automatic test_unknown();
        pkt = '{8'h55, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB};
        send_pkt();
        wait_idle("unknown");
        check_err("unknown", 1'b1);
        rx_byte(8'hEC);
        @(negedge clk_i);
        check_err("err_clear", 1'b0);
        @(posedge clk_i);
        #1;
        rx_byte(8'h00); rx_byte(8'h04); rx_byte(8'h00);
        wait_idle("after_unknown");
        check_err("after_unknown", 1'b0);
    endtask

    task automatic test_back_to_back();
        pkt = '{8'hA0, 8'h00, 8'h10, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h00,
                8'h14, 8'h00, 8'h00, 8'h00, 8'h1E, 8'h00, 8'h00, 8'h00,
                8'hEC, 8'h00, 8'h05, 8'h00, 8'h99};
        exp_q.push_back(8'h3C); exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        exp_q.push_back(8'h99);
        send_pkt();
        wait_idle("back_to_back");
        check_err("back_to_back", 1'b0);
    endtask

    task automatic test_mul();
        pkt = '{8'hA1, 8'h00, 8'h0C, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
`ifdef UART_ALU_MUL_EN
        exp_q.push_back(8'h0F); exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        send_pkt();
        wait_idle("mul");
        check_err("mul", 1'b0);
`else
        send_pkt();
        wait_idle("mul");
        check_err("mul", 1'b1);
`endif
    endtask

    task automatic test_reset_mid_send();
        pkt = '{8'hA0, 8'h00, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
        tx_ready_i = 1'b0;
        send_pkt();
        @(negedge clk_i);
        tests_run += 2;
        if (tx_valid_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL send_valid: got %0b, required 1", tx_valid_o); end
        if (tx_data_o !== 8'h05) begin tests_failed++; $display("[TB] FAIL send_data: got %02h, required 05", tx_data_o); end
        #1;
        reset_i = 1'b1;
        #1;
        tests_run += 3;
        if (tx_valid_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_tx_valid: got %0b, required 0", tx_valid_o); end
        if (busy_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_busy: got %0b, required 0", busy_o); end
        if (rx_ready_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL rst_rx_ready: got %0b, required 1", rx_ready_o); end
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        tx_ready_i = 1'b1;
        pkt = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h77};
        exp_q.push_back(8'h77);
        send_pkt();
        wait_idle("post_reset");
        check_err("post_reset", 1'b0);
    endtask

    initial begin
        test_reset();
        test_echo();
        test_add();
        test_add_wrap_stall();
        test_edge_lengths();
        test_unknown();
        test_back_to_back();
        test_mul();
        test_reset_mid_send();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
